counter_step_seq: RTL

COUNTER_STEP_SEQ -- requirements
Module: counter_step_seq

---
 rtl/counter_step_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/counter_step_seq.sv
// Sweep sequencer: clears the counter ICs, then steps through STEP_COUNT points with a settle and
// sample handshake at each. Define COUNTER_STEP_SEQ_TIMEOUT_EN to enable the 256-cycle ack timeout.
module counter_step_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [15:0] STEP_COUNT,
  input  logic [3:0]  PULSE_LEN,
  input  logic [7:0]  SETTLE_LEN,
  input  logic        SAMPLE_ACK,
  output logic        ADVANCE_COUNTER,
  output logic        RESET_COUNTER,
  output logic        SAMPLE_REQ,
  output logic [15:0] STEP_INDEX,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClr    = 3'd1;
  localparam logic [2:0] StGap    = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StSample = 3'd4;
  localparam logic [2:0] StAdv    = 3'd5;
  localparam logic [2:0] StFin    = 3'd6;

  localparam logic [7:0] GapLoad = 8'd3;

  logic [2:0]  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] step_count_q;
  logic [3:0]  pulse_len_q;
  logic [7:0]  settle_len_q;
  logic [15:0] step_index_q, step_index_d;
  logic        done_d;
  logic        sweep_start;
  logic [3:0]  pulse_len_eff;

  assign pulse_len_eff = (PULSE_LEN == 4'd0) ? 4'd1 : PULSE_LEN;

`ifdef COUNTER_STEP_SEQ_TIMEOUT_EN
  logic [7:0] ack_wait_q;
  logic       timeout;
  logic       timeout_hit;
  logic       error_q;

  // Counts cycles spent in SAMPLE; restarts from zero on every entry.
  assign timeout = (state_q == StSample) && (ack_wait_q == 8'hFF);
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    step_index_d = step_index_q;
    done_d       = 1'b0;
    sweep_start  = 1'b0;
`ifdef COUNTER_STEP_SEQ_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    if (ABORT) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (START) begin
            if (STEP_COUNT == 16'd0) begin
              done_d = 1'b1;
            end else begin
              sweep_start  = 1'b1;
              step_index_d = 16'd0;
              timer_d      = {4'd0, pulse_len_eff} - 8'd1;
              state_d      = StClr;
            end
          end
        end
        StClr, StAdv: begin
          if (timer_q == 8'd0) begin
            timer_d = GapLoad;
            state_d = StGap;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        StGap: begin
          if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
          end else if (settle_len_q == 8'd0) begin
            state_d = StSample;
          end else begin
            timer_d = settle_len_q - 8'd1;
            state_d = StSettle;
          end
        end
        StSettle: begin
          if (timer_q == 8'd0) begin
            state_d = StSample;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        StSample: begin
          if (SAMPLE_ACK) begin
            if (step_index_q == step_count_q - 16'd1) begin
              done_d  = 1'b1;
              state_d = StFin;
            end else begin
              step_index_d = step_index_q + 16'd1;
              timer_d      = {4'd0, pulse_len_q} - 8'd1;
              state_d      = StAdv;
            end
          end
`ifdef COUNTER_STEP_SEQ_TIMEOUT_EN
          else if (timeout) begin
            timeout_hit = 1'b1;
            state_d     = StIdle;
          end
`endif
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= StIdle;
      timer_q         <= 8'd0;
      step_count_q    <= 16'd0;
      pulse_len_q     <= 4'd1;
      settle_len_q    <= 8'd0;
      step_index_q    <= 16'd0;
      ADVANCE_COUNTER <= 1'b0;
      RESET_COUNTER   <= 1'b0;
      SAMPLE_REQ      <= 1'b0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      step_index_q    <= step_index_d;
      ADVANCE_COUNTER <= (state_d == StAdv);
      RESET_COUNTER   <= (state_d == StClr);
      SAMPLE_REQ      <= (state_d == StSample);
      BUSY            <= (state_d != StIdle);
      DONE            <= done_d;
      if (sweep_start) begin
        step_count_q <= STEP_COUNT;
        pulse_len_q  <= pulse_len_eff;
        settle_len_q <= SETTLE_LEN;
      end
    end
  end

  assign STEP_INDEX = step_index_q;

`ifdef COUNTER_STEP_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_wait_q <= 8'd0;
      error_q    <= 1'b0;
    end else begin
      ack_wait_q <= (state_q == StSample) ? ack_wait_q + 8'd1 : 8'd0;
      if (sweep_start) begin
        error_q <= 1'b0;
      end else if (timeout_hit) begin
        error_q <= 1'b1;
      end
    end
  end

  assign ERROR = error_q;
`else
  assign ERROR = 1'b0;
`endif

endmodule
